ins_fetch_queue: RTL and testbench

//  Prefetch stage between a variable-latency instruction memory and the ARM core decode/execute datapath.

---
 rtl/ins_fetch_queue.sv | 158 +++++++++++++++
 tb/tb_ins_fetch_queue.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_fetch_queue.sv
// Instruction prefetch queue: sequential +4 fetch over a req/ack memory bus into a small FIFO feeding the core.
// Optional performance counters are enabled with the FETCH_PERF_EN macro.
module ins_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          ins_valid,
  output logic [DW-1:0] ins,
  output logic [AW-1:0] ins_pc,
`ifdef FETCH_PERF_EN
  output logic [15:0]   perf_fetched,
  output logic [15:0]   perf_flushed,
`endif
  input  logic          ins_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] ins_mem_q [DEPTH];
  logic [AW-1:0] pc_mem_q  [DEPTH];

  logic [CW:0]   reserved;
  logic          issue;
  logic          push;
  logic          pop;
  logic          unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];

  // The outstanding request holds a FIFO slot so its response always fits.
  always_comb begin
    reserved  = {1'b0, cnt_q} + {{CW{1'b0}}, (state_q != IDLE)};
    issue     = !rst && !redirect && (state_q == IDLE) && (reserved < (CW+1)'(DEPTH));
    push      = (state_q == WAIT) && mem_ack && !redirect;
    ins_valid = (cnt_q != '0);
    pop       = ins_valid && ins_ready;
    mem_req   = issue || (state_q != IDLE);
    mem_addr  = (state_q == IDLE) ? fetch_pc_q : req_addr_q;
    ins       = ins_mem_q[rd_ptr_q];
    ins_pc    = pc_mem_q[rd_ptr_q];
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d    = WAIT;
          req_addr_d = fetch_pc_q;
        end
      end
      WAIT: begin
        if (mem_ack)       state_d = IDLE;
        else if (redirect) state_d = DROP;
      end
      DROP: begin
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (push)     fetch_pc_d = fetch_pc_q + AW'(4);
    if (redirect) fetch_pc_d = {redirect_pc[AW-1:2], 2'b00};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      req_addr_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Storage is cleared on reset so the head reads zero before the first fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ins_mem_q[i] <= '0;
        pc_mem_q[i]  <= '0;
      end
    end else if (push) begin
      ins_mem_q[wr_ptr_q] <= mem_rdata;
      pc_mem_q[wr_ptr_q]  <= fetch_pc_q;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0]   perf_fetched_q, perf_fetched_d;
  logic [15:0]   perf_flushed_q, perf_flushed_d;
  logic [CW-1:0] cleared;
  logic          discard;
  logic [16:0]   flush_sum;

  // Entries popped in the redirect cycle reached the core and are not flushes.
  always_comb begin
    discard        = mem_ack && (state_q != IDLE) && !push;
    cleared        = redirect ? (cnt_q - CW'(pop)) : '0;
    perf_fetched_d = perf_fetched_q;
    if (push && (perf_fetched_q != 16'hFFFF)) perf_fetched_d = perf_fetched_q + 16'd1;
    flush_sum      = {1'b0, perf_flushed_q} + 17'(cleared) + 17'(discard);
    perf_flushed_d = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Directed bench for ins_fetch_queue: streaming, backpressure, redirects, reset and PC wrap.
module tb_ins_fetch_queue;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ins_valid;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_ready;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_flushed;
`endif

  logic        mem_auto;
  logic        auto_ack;
  logic [31:0] auto_rdata;
  logic        man_ack;
  logic [31:0] man_rdata;
  logic        waited;

  int n_checks;
  int n_fail;

  assign mem_ack   = mem_auto ? auto_ack : man_ack;
  assign mem_rdata = mem_auto ? auto_rdata : man_rdata;

  ins_fetch_queue #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .ins_valid   (ins_valid),
    .ins         (ins),
    .ins_pc      (ins_pc),
`ifdef FETCH_PERF_EN
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed),
`endif
    .ins_ready   (ins_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory image: word at address A is 0xE0000000 | A; ack one cycle after req is seen.
  initial begin
    auto_ack   = 1'b0;
    auto_rdata = '0;
    waited     = 1'b0;
    forever begin
      @(negedge clk);
      if (!mem_auto) begin
        auto_ack = 1'b0;
        waited   = 1'b0;
      end else begin
        if (auto_ack) begin
          auto_ack = 1'b0;
          waited   = 1'b0;
        end
        if (mem_req) begin
          if (waited) begin
            auto_ack   = 1'b1;
            auto_rdata = 32'hE000_0000 | mem_addr;
          end else begin
            waited = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mem_auto    = 1'b0;
    man_ack     = 1'b0;
    man_rdata   = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    ins_ready   = 1'b0;
    rst         = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Called in the cycle a request is issued from IDLE; acks it one cycle later.
  task automatic serve_one();
    step();
    man_ack   = 1'b1;
    man_rdata = 32'hE000_0000 | mem_addr;
    step();
    man_ack = 1'b0;
  endtask

  task automatic test_reset();
    mem_auto = 1'b0; man_ack = 1'b0; man_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; ins_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %0b expected 0", mem_req); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 00000000", mem_addr); end
    n_checks++; if (ins_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ins_valid: got %0b expected 0", ins_valid); end
    n_checks++; if (ins !== 32'h0) begin n_fail++; $display("FAIL reset_ins: got %h expected 00000000", ins); end
    n_checks++; if (ins_pc !== 32'h0) begin n_fail++; $display("FAIL reset_ins_pc: got %h expected 00000000", ins_pc); end
  endtask

  task automatic test_streaming();
    do_reset();
    ins_ready = 1'b1;
    mem_auto  = 1'b1;
    step();
    step();
    #1;
    n_checks++; if (ins_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid0: got %0b expected 1", ins_valid); end
    n_checks++; if (ins_pc !== 32'h0) begin n_fail++; $display("FAIL stream_pc0: got %h expected 00000000", ins_pc); end
    n_checks++; if (ins !== 32'hE000_0000) begin n_fail++; $display("FAIL stream_ins0: got %h expected e0000000", ins); end
    for (int k = 1; k <= 3; k++) begin
      step();
      #1;
      n_checks++; if (ins_valid !== 1'b0) begin n_fail++; $display("FAIL stream_gap%0d: got %0b expected 0", k, ins_valid); end
      step();
      #1;
      n_checks++; if (ins_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid%0d: got %0b expected 1", k, ins_valid); end
      n_checks++; if (ins_pc !== 32'(4 * k)) begin n_fail++; $display("FAIL stream_pc%0d: got %h expected %h", k, ins_pc, 32'(4 * k)); end
      n_checks++; if (ins !== (32'hE000_0000 + 32'(4 * k))) begin n_fail++; $display("FAIL stream_ins%0d: got %h expected %h", k, ins, 32'hE000_0000 + 32'(4 * k)); end
    end
    mem_auto = 1'b0;
  endtask

  task automatic test_backpressure();
    int          issued;
    logic        prev_req;
    logic [31:0] prev_addr;
    do_reset();
    ins_ready = 1'b0;
    mem_auto  = 1'b1;
    #1;
    issued    = 0;
    prev_req  = 1'b0;
    prev_addr = '1;
    for (int i = 0; i < 16; i++) begin
      if (mem_req && (!prev_req || mem_addr != prev_addr)) issued++;
      prev_req  = mem_req;
      prev_addr = mem_addr;
      step();
      #1;
    end
    n_checks++; if (issued != 4) begin n_fail++; $display("FAIL bp_issued: got %0d expected 4", issued); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_stall: got %0b expected 0", mem_req); end
    n_checks++; if (ins_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %0b expected 1", ins_valid); end
    n_checks++; if (ins_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head_pc: got %h expected 00000000", ins_pc); end
    n_checks++; if (ins !== 32'hE000_0000) begin n_fail++; $display("FAIL bp_head_ins: got %h expected e0000000", ins); end
    ins_ready = 1'b1;
    step();
    ins_ready = 1'b0;
    #1;
    n_checks++; if (ins_pc !== 32'h4) begin n_fail++; $display("FAIL bp_pop_pc: got %h expected 00000004", ins_pc); end
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL bp_new_req: got %0b expected 1", mem_req); end
    n_checks++; if (mem_addr !== 32'h10) begin n_fail++; $display("FAIL bp_new_addr: got %h expected 00000010", mem_addr); end
    mem_auto = 1'b0;
  endtask

  task automatic test_redirect_wait();
    do_reset();
    serve_one();
    serve_one();
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    step();
    redirect = 1'b0;
    #1;
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL drop_req_held: got %0b expected 1", mem_req); end
    n_checks++; if (mem_addr !== 32'h8) begin n_fail++; $display("FAIL drop_addr_held: got %h expected 00000008", mem_addr); end
    n_checks++; if (ins_valid !== 1'b0) begin n_fail++; $display("FAIL drop_flushed: got %0b expected 0", ins_valid); end
    step();
    man_ack   = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    step();
    man_ack = 1'b0;
    #1;
    n_checks++; if (ins_valid !== 1'b0) begin n_fail++; $display("FAIL drop_discard: got %0b expected 0", ins_valid); end
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL drop_next_req: got %0b expected 1", mem_req); end
    n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL drop_next_addr: got %h expected 00000100", mem_addr); end
    serve_one();
    #1;
    n_checks++; if (ins_valid !== 1'b1) begin n_fail++; $display("FAIL drop_first_valid: got %0b expected 1", ins_valid); end
    n_checks++; if (ins_pc !== 32'h100) begin n_fail++; $display("FAIL drop_first_pc: got %h expected 00000100", ins_pc); end
    n_checks++; if (ins !== 32'hE000_0100) begin n_fail++; $display("FAIL drop_first_ins: got %h expected e0000100", ins); end
  endtask

  task automatic test_redirect_ack_pop();
    do_reset();
    serve_one();
    serve_one();
    step();
    man_ack     = 1'b1;
    man_rdata   = 32'h1234_5678;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    ins_ready   = 1'b1;
    step();
    man_ack   = 1'b0;
    redirect  = 1'b0;
    ins_ready = 1'b0;
    #1;
    n_checks++; if (ins_valid !== 1'b0) begin n_fail++; $display("FAIL coinc_valid: got %0b expected 0", ins_valid); end
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL coinc_req: got %0b expected 1", mem_req); end
    n_checks++; if (mem_addr !== 32'h40) begin n_fail++; $display("FAIL coinc_addr: got %h expected 00000040", mem_addr); end
    serve_one();
    #1;
    n_checks++; if (ins_valid !== 1'b1) begin n_fail++; $display("FAIL coinc_next_valid: got %0b expected 1", ins_valid); end
    n_checks++; if (ins_pc !== 32'h40) begin n_fail++; $display("FAIL coinc_next_pc: got %h expected 00000040", ins_pc); end
    n_checks++; if (ins !== 32'hE000_0040) begin n_fail++; $display("FAIL coinc_next_ins: got %h expected e0000040", ins); end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    serve_one();
    serve_one();
    serve_one();
    step();
    rst = 1'b1;
    step();
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req: got %0b expected 0", mem_req); end
    n_checks++; if (ins_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %0b expected 0", ins_valid); end
    step();
    rst = 1'b0;
    #1;
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_first_req: got %0b expected 1", mem_req); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rstmid_first_addr: got %h expected 00000000", mem_addr); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL wrap_no_issue: got %0b expected 0", mem_req); end
    step();
    redirect = 1'b0;
    #1;
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_req: got %0b expected 1", mem_req); end
    n_checks++; if (mem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_masked_addr: got %h expected fffffffc", mem_addr); end
    serve_one();
    #1;
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next_addr: got %h expected 00000000", mem_addr); end
    n_checks++; if (ins_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_ins_pc: got %h expected fffffffc", ins_pc); end
    n_checks++; if (ins !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_ins: got %h expected fffffffc", ins); end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    do_reset();
    ins_ready = 1'b1;
    serve_one();
    serve_one();
    serve_one();
    step();
    ins_ready = 1'b0;
    man_ack   = 1'b1;
    man_rdata = 32'hE000_000C;
    step();
    man_ack = 1'b0;
    serve_one();
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    man_ack  = 1'b1;
    step();
    man_ack = 1'b0;
    #1;
    n_checks++; if (perf_fetched !== 16'd5) begin n_fail++; $display("FAIL perf_fetched: got %0d expected 5", perf_fetched); end
    n_checks++; if (perf_flushed !== 16'd3) begin n_fail++; $display("FAIL perf_flushed: got %0d expected 3", perf_flushed); end
    force dut.perf_fetched_q = 16'hFFFF;
    force dut.perf_flushed_q = 16'hFFFF;
    step();
    release dut.perf_fetched_q;
    release dut.perf_flushed_q;
    man_ack   = 1'b1;
    man_rdata = 32'hE000_0200;
    step();
    man_ack     = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    #1;
    n_checks++; if (perf_fetched !== 16'hFFFF) begin n_fail++; $display("FAIL perf_fetched_sat: got %h expected ffff", perf_fetched); end
    n_checks++; if (perf_flushed !== 16'hFFFF) begin n_fail++; $display("FAIL perf_flushed_sat: got %h expected ffff", perf_flushed); end
  endtask
`endif

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    ins_ready   = 1'b0;
    mem_auto    = 1'b0;
    man_ack     = 1'b0;
    man_rdata   = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_wait();
    test_redirect_ack_pop();
    test_reset_mid_fetch();
    test_pc_wrap();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
